// File: rtl/pc_next_unit_pkg.sv
// Shared constants for the program-counter unit: B-type funct3 encodings and FSM states.
package pc_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_next_unit_branch_cond.sv
// Resolves the B-type branch condition from funct3 and the ALU compare flags.
module branch_cond
  import pc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       cond
);

  always_comb begin
    cond = 1'b0;
    case (funct3)
      F3_BEQ:  cond = zero;
      F3_BNE:  cond = ~zero;
      F3_BLT:  cond = lt;
      F3_BGE:  cond = ~lt;
      F3_BLTU: cond = ltu;
      F3_BGEU: cond = ~ltu;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_next_unit.sv
// Registered PC with next-PC selection (seq/branch/JAL/JALR), stall hold, boot cycle and flush pulse.
// Optional build macro MISALIGN_TRAP_EN redirects misaligned targets to TRAP_VEC and pulses misaligned.
module pc_next_unit
  import pc_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              INC      = 4
`ifdef MISALIGN_TRAP_EN
  ,
  parameter logic [XLEN-1:0] TRAP_VEC = XLEN'('h4)
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch,
  input  logic            jump,
  input  logic            jalr,
  input  logic [2:0]      funct3,
  input  logic            zero,
  input  logic            lt,
  input  logic            ltu,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic            pc_valid,
  output logic            flush,
  output logic            taken,
  output logic            misaligned,
  output pc_state_e       dbg_state
);

  localparam logic [XLEN-1:0] INC_W = XLEN'(INC);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_inc, br_target, jalr_sum, target, redirect_pc;
  logic            cond, redirect_req;

  branch_cond u_branch_cond (
    .funct3 (funct3),
    .zero   (zero),
    .lt     (lt),
    .ltu    (ltu),
    .cond   (cond)
  );

  assign pc_inc    = pc_q + INC_W;
  assign br_target = pc_q + imm;
  assign jalr_sum  = rs1 + imm;
  // JALR clears bit 0; JAL and branches share the pc-relative adder.
  assign target    = jalr ? (jalr_sum & ~XLEN'(1)) : br_target;

  assign redirect_req = jalr | jump | (branch & cond);
  assign taken        = (state_q != BOOT) & ~stall & redirect_req;

`ifdef MISALIGN_TRAP_EN
  logic target_mis, mis_q;
  assign target_mis  = |target[1:0];
  assign redirect_pc = target_mis ? TRAP_VEC : target;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= taken & target_mis;
  end
  assign misaligned = mis_q;
`else
  assign redirect_pc = target;
  assign misaligned  = 1'b0;
`endif

  always_comb begin
    pc_d = pc_q;
    if (taken)                             pc_d = redirect_pc;
    else if ((state_q != BOOT) && !stall)  pc_d = pc_inc;
  end

  always_comb begin
    state_d = state_q;
    if (!stall) begin
      case (state_q)
        BOOT:    state_d = RUN;
        RUN:     state_d = taken ? FLUSH : RUN;
        FLUSH:   state_d = taken ? FLUSH : RUN;
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      state_q <= BOOT;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign pc        = pc_q;
  assign pc_plus   = pc_inc;
  assign pc_valid  = (state_q != BOOT);
  assign flush     = (state_q == FLUSH);
  assign dbg_state = state_q;

endmodule
